// File: rtl/wb_sel_pkg.sv
// Shared definitions for the writeback-select stage.
//   a_sel_e      : write-address select encodings (rt / rd / link / illegal)
//   SRC_*        : conventional write-data source indices
//   DATA_W_DEF / ADDR_W_DEF : default datapath and register-address widths
package wb_sel_pkg;

  typedef enum logic [1:0] {
    A_SEL_RT   = 2'b00,
    A_SEL_RD   = 2'b01,
    A_SEL_LINK = 2'b10,
    A_SEL_BAD  = 2'b11
  } a_sel_e;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam int SRC_ALU = 0;
  localparam int SRC_DM  = 1;
  localparam int SRC_PC8 = 2;

endpackage

// File: rtl/wb_sel_pipe_src_mux.sv
// wb_src_mux: combinational NSRC-way write-data selector.
//   src_data in  NSRC*DATA_W  packed sources, source k = [k*DATA_W +: DATA_W]
//   d_sel    in  SEL_W        source index
//   data     out DATA_W       selected source (zero when index is out of range)
//   bad      out 1            index >= NSRC
module wb_src_mux
  import wb_sel_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NSRC   = 3,
  parameter int SEL_W  = 2
) (
  input  logic [NSRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]       d_sel,
  output logic [DATA_W-1:0]      data,
  output logic                   bad
);

  always_comb begin
    data = '0;
    bad  = 1'b1;
    for (int k = 0; k < NSRC; k++) begin
      if (d_sel == SEL_W'(k)) begin
        data = src_data[k*DATA_W +: DATA_W];
        bad  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/wb_sel_pipe.sv
// wb_sel_pipe: registered MEM/WB writeback-select stage.
// Merges write-address select (rt/rd/link) and NSRC-way write-data select,
// suppresses x0 writes, flags illegal selects (sticky) and counts committed
// writes. Optional GRF read bypass enabled by defining WB_BYPASS_EN.
// Ports:
//   clk, reset (sync, active-high), stall (hold), flush (bubble)
//   in_valid, instr (rt=[20:16], rd=[15:11]), a_sel, d_sel, src_data
//   wb_valid, wb_we, wb_addr, wb_data : registered GRF write port
//   sel_err : sticky illegal-select flag, wb_cnt : committed-write counter
//   byp_raddr, byp_rdata_i -> byp_rdata_o : GRF read data after bypass
module wb_sel_pipe
  import wb_sel_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NSRC     = 3,
  parameter int SEL_W    = 2,
  parameter int LINK_REG = 31
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [31:0]            instr,
  input  logic [1:0]             a_sel,
  input  logic [SEL_W-1:0]       d_sel,
  input  logic [NSRC*DATA_W-1:0] src_data,
  output logic                   wb_valid,
  output logic                   wb_we,
  output logic [ADDR_W-1:0]      wb_addr,
  output logic [DATA_W-1:0]      wb_data,
  output logic                   sel_err,
  output logic [31:0]            wb_cnt,
  input  logic [ADDR_W-1:0]      byp_raddr,
  input  logic [DATA_W-1:0]      byp_rdata_i,
  output logic [DATA_W-1:0]      byp_rdata_o
);

  a_sel_e              a_sel_p0;
  logic [ADDR_W-1:0]   addr_p0;
  logic [DATA_W-1:0]   data_p0;
  logic                d_bad_p0;
  logic                sel_bad_p0;
  logic                we_p0;

  logic                vld_p1;
  logic                we_p1;
  logic [ADDR_W-1:0]   addr_p1;
  logic [DATA_W-1:0]   data_p1;
  logic                err_p1;
  logic [31:0]         cnt_p1;

  logic                unused_bits;

  // ---- stage p0: combinational address/data select ----
  assign a_sel_p0 = a_sel_e'(a_sel);

  always_comb begin
    addr_p0 = '0;
    case (a_sel_p0)
      A_SEL_RT:   addr_p0 = ADDR_W'(instr[20:16]);
      A_SEL_RD:   addr_p0 = ADDR_W'(instr[15:11]);
      A_SEL_LINK: addr_p0 = ADDR_W'(LINK_REG);
      default:    addr_p0 = '0;
    endcase
  end

  wb_src_mux #(
    .DATA_W (DATA_W),
    .NSRC   (NSRC),
    .SEL_W  (SEL_W)
  ) u_src_mux (
    .src_data (src_data),
    .d_sel    (d_sel),
    .data     (data_p0),
    .bad      (d_bad_p0)
  );

  assign sel_bad_p0 = (a_sel_p0 == A_SEL_BAD) | d_bad_p0;
  // x0 is hard-wired zero in the GRF, so a write there is never enabled.
  assign we_p0      = in_valid & ~sel_bad_p0 & (addr_p0 != '0);

  // ---- stage p1: MEM/WB boundary register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      we_p1   <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
      err_p1  <= 1'b0;
      cnt_p1  <= '0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      we_p1   <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else if (!stall) begin
      vld_p1 <= in_valid;
      if (in_valid && sel_bad_p0) begin
        // Illegal select on a live instruction: drop the write, latch error.
        we_p1   <= 1'b0;
        addr_p1 <= '0;
        data_p1 <= '0;
        err_p1  <= 1'b1;
      end else begin
        we_p1   <= we_p0;
        addr_p1 <= addr_p0;
        data_p1 <= data_p0;
      end
      if (we_p0) begin
        cnt_p1 <= cnt_p1 + 32'd1;
      end
    end
  end

  assign wb_valid = vld_p1;
  assign wb_we    = we_p1;
  assign wb_addr  = addr_p1;
  assign wb_data  = data_p1;
  assign sel_err  = err_p1;
  assign wb_cnt   = cnt_p1;

  // ---- bypass: combinational from the registered write port ----
`ifdef WB_BYPASS_EN
  assign byp_rdata_o = (we_p1 && (addr_p1 == byp_raddr) && (byp_raddr != '0))
                       ? data_p1 : byp_rdata_i;
`else
  assign byp_rdata_o = byp_rdata_i;
`endif

  // Instruction fields outside rt/rd are not needed at this stage.
  assign unused_bits = ^{instr[31:21], instr[10:0], byp_raddr};

endmodule

// File: tb/tb_wb_sel_pipe.sv
module tb_wb_sel_pipe;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NSRC   = 3;
  localparam int SEL_W  = 2;

  logic                   clk = 1'b0;
  logic                   reset, stall, flush, in_valid;
  logic [31:0]            instr;
  logic [1:0]             a_sel;
  logic [SEL_W-1:0]       d_sel;
  logic [NSRC*DATA_W-1:0] src_data;
  logic                   wb_valid, wb_we, sel_err;
  logic [ADDR_W-1:0]      wb_addr, byp_raddr;
  logic [DATA_W-1:0]      wb_data, byp_rdata_i, byp_rdata_o;
  logic [31:0]            wb_cnt;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic              m_valid, m_we, m_err;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic [31:0]       m_cnt;

  always #5 clk = ~clk;

  wb_sel_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NSRC(NSRC), .SEL_W(SEL_W), .LINK_REG(31)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .instr(instr), .a_sel(a_sel), .d_sel(d_sel), .src_data(src_data),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .sel_err(sel_err), .wb_cnt(wb_cnt), .byp_raddr(byp_raddr),
    .byp_rdata_i(byp_rdata_i), .byp_rdata_o(byp_rdata_o)
  );

  // Next state of the writeback register from the current inputs.
  task automatic model_update();
    int target;
    bit legal;
    if (reset) begin
      m_valid = 0; m_we = 0; m_addr = 0; m_data = 0; m_err = 0; m_cnt = 0;
    end else if (flush) begin
      m_valid = 0; m_we = 0; m_addr = 0; m_data = 0;
    end else if (!stall) begin
      legal = (a_sel != 2'd3) && (int'(d_sel) < NSRC);
      if (a_sel == 2'd0)      target = int'(instr[20:16]);
      else if (a_sel == 2'd1) target = int'(instr[15:11]);
      else if (a_sel == 2'd2) target = 31;
      else                    target = 0;
      m_valid = in_valid;
      if (in_valid && !legal) begin
        m_we = 0; m_addr = 0; m_data = 0; m_err = 1;
      end else begin
        m_we   = in_valid && legal && (target != 0);
        m_addr = ADDR_W'(target);
        m_data = (int'(d_sel) < NSRC) ? src_data[int'(d_sel)*DATA_W +: DATA_W] : '0;
        if (m_we) m_cnt = m_cnt + 32'd1;
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input logic [1:0] as, input logic [SEL_W-1:0] ds,
                        input int rt, input int rd);
    in_valid = v;
    a_sel    = as;
    d_sel    = ds;
    instr    = {$urandom_range(2047, 0) > 0 ? 11'h5a5 : 11'h0, 5'(rt), 5'(rd), 11'h3c3};
  endtask

  task automatic set_src(input logic [31:0] alu, input logic [31:0] dm, input logic [31:0] pc8);
    src_data = {pc8, dm, alu};
  endtask

  task automatic test_reset();
    reset = 1; stall = 0; flush = 0;
    set_in(1, 2'd1, 2'd0, 3, 7);
    set_src(32'h1234_5678, 32'h9, 32'ha);
    tick();
    reset = 0;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", wb_valid); end
    total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%0b exp=0", wb_we); end
    total++; if (wb_addr !== '0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", wb_addr); end
    total++; if (wb_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", wb_data); end
    total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", sel_err); end
    total++; if (wb_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", wb_cnt); end
  endtask

  task automatic test_basic();
    set_in(1, 2'd1, 2'd0, 0, 8);
    set_src(32'hDEAD_BEEF, 32'h1111_1111, 32'h2222_2222);
    tick();
    total++; if (wb_we !== 1'b1) begin bad++; $display("FAIL basic_we got=%0b exp=1", wb_we); end
    total++; if (wb_addr !== 5'd8) begin bad++; $display("FAIL basic_addr got=%0d exp=8", wb_addr); end
    total++; if (wb_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL basic_data got=%h exp=deadbeef", wb_data); end
    total++; if (wb_cnt !== 32'd1) begin bad++; $display("FAIL basic_cnt got=%0d exp=1", wb_cnt); end
  endtask

  task automatic test_link();
    set_in(1, 2'd2, 2'd2, 4, 9);
    set_src(32'h5, 32'h6, 32'h0000_3008);
    tick();
    total++; if (wb_addr !== 5'd31) begin bad++; $display("FAIL link_addr got=%0d exp=31", wb_addr); end
    total++; if (wb_data !== 32'h0000_3008) begin bad++; $display("FAIL link_data got=%h exp=00003008", wb_data); end
    total++; if (wb_cnt !== 32'd2) begin bad++; $display("FAIL link_cnt got=%0d exp=2", wb_cnt); end
    set_in(1, 2'd0, 2'd0, 0, 12);
    tick();
    total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL x0_we got=%0b exp=0", wb_we); end
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL x0_valid got=%0b exp=1", wb_valid); end
    total++; if (wb_cnt !== 32'd2) begin bad++; $display("FAIL x0_cnt got=%0d exp=2", wb_cnt); end
  endtask

  task automatic test_stall();
    set_in(1, 2'd0, 2'd1, 17, 3);
    set_src(32'h1, 32'hCAFE_F00D, 32'h3);
    tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 2'd1, 2'd0, 2, 20 + i);
      set_src($urandom, $urandom, $urandom);
      tick();
      total++; if (wb_addr !== 5'd17 || wb_data !== 32'hCAFE_F00D || wb_we !== 1'b1)
        begin bad++; $display("FAIL stall_hold got=%0d/%h/%0b exp=17/cafef00d/1", wb_addr, wb_data, wb_we); end
      total++; if (wb_cnt !== 32'd3) begin bad++; $display("FAIL stall_cnt got=%0d exp=3", wb_cnt); end
    end
    flush = 1;
    tick();
    stall = 0; flush = 0;
    total++; if (wb_valid !== 1'b0 || wb_we !== 1'b0) begin bad++; $display("FAIL flush_bubble got=%0b/%0b exp=0/0", wb_valid, wb_we); end
    total++; if (wb_addr !== '0 || wb_data !== '0) begin bad++; $display("FAIL flush_clear got=%0d/%h exp=0/0", wb_addr, wb_data); end
    total++; if (wb_cnt !== 32'd3) begin bad++; $display("FAIL flush_cnt got=%0d exp=3", wb_cnt); end
  endtask

  task automatic test_sel_err();
    set_in(0, 2'd3, 2'd3, 5, 5);
    tick();
    total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL err_ignored got=%0b exp=0", sel_err); end
    set_in(1, 2'd3, 2'd0, 5, 5);
    tick();
    total++; if (wb_we !== 1'b0 || sel_err !== 1'b1) begin bad++; $display("FAIL err_asel got=%0b/%0b exp=0/1", wb_we, sel_err); end
    set_in(1, 2'd1, 2'd1, 0, 6);
    tick();
    total++; if (wb_we !== 1'b1 || sel_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%0b/%0b exp=1/1", wb_we, sel_err); end
    reset = 1; tick(); reset = 0;
    set_in(1, 2'd1, 2'd3, 0, 4);
    tick();
    total++; if (wb_we !== 1'b0 || sel_err !== 1'b1 || wb_data !== '0) begin bad++; $display("FAIL err_dsel got=%0b/%0b/%h exp=0/1/0", wb_we, sel_err, wb_data); end
    reset = 1; tick(); reset = 0;
    total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%0b exp=0", sel_err); end
  endtask

  task automatic test_wrap();
    force dut.cnt_p1 = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_p1;
    m_cnt = 32'hFFFF_FFFF;
    total++; if (wb_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_preload got=%h exp=ffffffff", wb_cnt); end
    set_in(1, 2'd1, 2'd0, 0, 10);
    tick();
    total++; if (wb_cnt !== 32'd0) begin bad++; $display("FAIL wrap_cnt got=%h exp=0", wb_cnt); end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_hit;
    set_in(1, 2'd1, 2'd0, 0, 5);
    set_src(32'h11, 32'h0, 32'h0);
    tick();
`ifdef WB_BYPASS_EN
    exp_hit = 32'h11;
`else
    exp_hit = 32'h22;
`endif
    byp_rdata_i = 32'h22;
    byp_raddr = 5'd5; #1;
    total++; if (byp_rdata_o !== exp_hit) begin bad++; $display("FAIL byp_hit got=%h exp=%h", byp_rdata_o, exp_hit); end
    byp_raddr = 5'd0; #1;
    total++; if (byp_rdata_o !== 32'h22) begin bad++; $display("FAIL byp_x0 got=%h exp=22", byp_rdata_o); end
    byp_raddr = 5'd6; #1;
    total++; if (byp_rdata_o !== 32'h22) begin bad++; $display("FAIL byp_miss got=%h exp=22", byp_rdata_o); end
  endtask

  task automatic test_random();
    logic [31:0] exp_byp;
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(99, 0) < 20);
      flush = ($urandom_range(99, 0) < 8);
      set_in($urandom_range(9, 0) < 8, 2'($urandom_range(3, 0)), SEL_W'($urandom_range(3, 0)),
             $urandom_range(31, 0) & ($urandom_range(3, 0) == 0 ? 0 : 31), $urandom_range(31, 0));
      set_src($urandom, $urandom, $urandom);
      byp_raddr   = ($urandom_range(1, 0) == 1) ? m_addr : 5'($urandom_range(31, 0));
      byp_rdata_i = $urandom;
      tick();
`ifdef WB_BYPASS_EN
      exp_byp = (m_we && m_addr == byp_raddr && byp_raddr != 0) ? m_data : byp_rdata_i;
`else
      exp_byp = byp_rdata_i;
`endif
      total++; if (wb_valid !== m_valid || wb_we !== m_we) begin bad++; $display("FAIL rnd_ctl i=%0d got=%0b/%0b exp=%0b/%0b", i, wb_valid, wb_we, m_valid, m_we); end
      if (m_valid) begin
        total++; if (wb_addr !== m_addr || wb_data !== m_data) begin bad++; $display("FAIL rnd_wb i=%0d got=%0d/%h exp=%0d/%h", i, wb_addr, wb_data, m_addr, m_data); end
      end
      total++; if (sel_err !== m_err || wb_cnt !== m_cnt) begin bad++; $display("FAIL rnd_state i=%0d got=%0b/%0d exp=%0b/%0d", i, sel_err, wb_cnt, m_err, m_cnt); end
      total++; if (byp_rdata_o !== exp_byp) begin bad++; $display("FAIL rnd_byp i=%0d got=%h exp=%h", i, byp_rdata_o, exp_byp); end
    end
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0; in_valid = 0; instr = '0; a_sel = '0; d_sel = '0;
    src_data = '0; byp_raddr = '0; byp_rdata_i = '0;
    test_reset();
    test_basic();
    test_link();
    test_stall();
    test_sel_err();
    test_wrap();
    test_bypass();
    reset = 1; tick(); reset = 0;
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
